seq_det_param: RTL and testbench
================================

SEQ_DET_PARAM -- requirements
Module: seq_det_param

Interface
REQ-001 Parameter N, default 3, is the pattern length in bits; the legal range is 2..16.
REQ-002 Parameter PATTERN, default 3'b101, is the [N-1:0] target sequence; PATTERN[N-1] is the first bit expected.
REQ-003 Parameter OVERLAP, default 1: 1 means overlapping detection, 0 means non-overlapping.
REQ-004 Parameter CNT_W, default 8, is the match counter width; the legal range is 1..32.
REQ-005 clk  input  1  is the single clock; all state changes on its rising edge.
REQ-006 rst  input  1  is the synchronous, active-high reset.
REQ-007 i  input  1  is the serial data bit.
REQ-008 en  input  1  is the bit-valid qualifier; i is accepted only on edges where en=1.
REQ-009 clr  input  1  is a synchronous clear of match_cnt only.
REQ-010 q  output  1  is the registered Mealy match pulse.
REQ-011 match_cnt  output  CNT_W  is the saturating count of detected matches.

Function
REQ-012 An "accepted bit" SHALL be the value of i sampled on a rising edge with rst=0 and en=1.
REQ-013 With OVERLAP=1, a match SHALL occur on an edge when the last N accepted bits, oldest first, equal PATTERN[N-1:0].
REQ-014 With OVERLAP=0, a match SHALL additionally require at least N accepted bits since the previous match or reset, so no bit is shared between two matches.
REQ-015 q SHALL be set to 1 on the edge that accepts a match-completing bit, and cleared to 0 on every other edge: no match, en=0, or rst=1.
REQ-016 q SHALL therefore be high for exactly one cycle per match, with no combinational path from i or en to q.
REQ-017 On edges with en=0, the detection history SHALL hold and q SHALL go to 0.
REQ-018 The detector SHALL be a state machine of match progress: state k means the longest tail of accepted bits equal to PATTERN's first k bits.
REQ-019 After a match, the next state SHALL be the longest proper prefix-suffix of PATTERN when OVERLAP=1, and 0 when OVERLAP=0.
REQ-020 Fewer than N accepted bits since reset SHALL never produce a match.
REQ-021 Patterns with self-overlap, such as all-ones or 1010, SHALL be handled exactly per REQ-013 and REQ-014.

Reset
REQ-022 rst=1 SHALL, on the next rising edge, clear q to 0, clear match_cnt to 0, and discard all detection history.
REQ-023 rst SHALL have priority over en, clr and i; a match in progress at reset is lost.
REQ-024 The first accepted bit after rst deasserts SHALL be treated as the oldest bit of history.

Configuration
REQ-025 Macro SEQ_DET_CNT_EN defined: match_cnt SHALL increment by 1 on every edge where q is set, and saturate at 2^CNT_W-1.
REQ-026 With SEQ_DET_CNT_EN defined, clr=1 SHALL zero match_cnt; a clr and a match on the same edge SHALL yield match_cnt=0.
REQ-027 Macro SEQ_DET_CNT_EN undefined: match_cnt SHALL be constant 0 with no counter flops, and clr SHALL be ignored; q behaviour is unchanged.

Verification
REQ-028 Defaults, en=1, i=1,0,1,0,1 -> q high in the cycles after the 3rd and 5th accepted bits, and match_cnt=2 (macro on).
REQ-029 OVERLAP=0, i=1,0,1,0,1 -> q high only after the 3rd bit; then i=0,1 -> q high after the 7th bit.
REQ-030 Defaults, i=1,0 with en=1, then en=0 for 3 cycles with i toggling, then i=1 with en=1 -> single q pulse after the en=1 edge, and q=0 during the gap.
REQ-031 N=4, PATTERN=4'b1111, OVERLAP=1, six 1s -> q pulses after the 4th, 5th and 6th bits; the same stimulus with OVERLAP=0 -> one pulse only, after the 4th bit.
REQ-032 Defaults, i=1,0 then rst=1 for one edge then i=1 -> no q pulse; CNT_W=2 with 5 matches -> match_cnt=3, and clr coincident with a match -> match_cnt=0.

Source files
------------

// File: rtl/seq_det_param.sv
// seq_det_param - parameterised serial pattern detector with registered match pulse
// Optional saturating match counter enabled by macro SEQ_DET_CNT_EN.
module seq_det_param #(
  parameter int          N       = 3,
  parameter logic [N-1:0] PATTERN = 3'b101,
  parameter bit          OVERLAP = 1'b1,
  parameter int          CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i,
  input  logic             en,
  input  logic             clr,
  output logic             q,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int          SW  = (N > 2) ? $clog2(N) : 1;
  localparam logic [31:0] PAT = 32'(PATTERN);

  // First len bits of the pattern as an MSB-first number.
  function automatic logic [31:0] prefix(input int len);
    return PAT >> (N - len);
  endfunction

  function automatic logic [31:0] low_mask(input int len);
    return (32'd1 << len) - 32'd1;
  endfunction

  // Longest pattern prefix that ends the string "prefix(k) followed by b".
  function automatic int advance(input int k, input logic b);
    logic [31:0] s;
    int          r;
    s = (prefix(k) << 1) | {31'd0, b};
    r = 0;
    for (int len = 1; len <= N; len++) begin
      if (len <= k + 1 && (s & low_mask(len)) == prefix(len)) r = len;
    end
    return r;
  endfunction

  function automatic int border();
    int r;
    r = 0;
    for (int len = 1; len < N; len++) begin
      if ((PAT & low_mask(len)) == prefix(len)) r = len;
    end
    return r;
  endfunction

  localparam int RESTART = OVERLAP ? border() : 0;

  typedef enum logic [SW-1:0] {S_IDLE = '0} state_t;

  state_t      state;
  int          adv;
  logic        hit;
  logic [SW-1:0] nxt;

  always_comb begin
    adv = advance(int'(state), i);
    hit = (adv == N);
    nxt = hit ? SW'(RESTART) : SW'(adv);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      q     <= 1'b0;
    end else if (en) begin
      state <= state_t'(nxt);
      q     <= hit;
    end else begin
      q     <= 1'b0;
    end
  end

`ifdef SEQ_DET_CNT_EN
  // clr wins over a coincident match.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      match_cnt <= '0;
    end else if (en && hit && match_cnt != {CNT_W{1'b1}}) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign match_cnt  = '0;
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// tb/tb_seq_det_param.sv - checks several seq_det_param configurations against a history model
module tb_seq_det_param;

  localparam int NI = 5;

  logic clk = 1'b0;
  logic rst, i, en, clr;
  logic       q_w [NI];
  logic [7:0] cnt_w [NI];
  logic [1:0] cnt4;

  always #5 clk = ~clk;

  int          cfg_n   [NI] = '{3, 3, 4, 4, 3};
  logic [15:0] cfg_pat [NI] = '{16'b101, 16'b101, 16'b1111, 16'b1111, 16'b101};
  bit          cfg_ovl [NI] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  int          cfg_max [NI] = '{255, 255, 255, 255, 3};

  seq_det_param #(.N(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CNT_W(8)) d0 (
    .clk(clk), .rst(rst), .i(i), .en(en), .clr(clr), .q(q_w[0]), .match_cnt(cnt_w[0]));
  seq_det_param #(.N(3), .PATTERN(3'b101), .OVERLAP(1'b0), .CNT_W(8)) d1 (
    .clk(clk), .rst(rst), .i(i), .en(en), .clr(clr), .q(q_w[1]), .match_cnt(cnt_w[1]));
  seq_det_param #(.N(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(8)) d2 (
    .clk(clk), .rst(rst), .i(i), .en(en), .clr(clr), .q(q_w[2]), .match_cnt(cnt_w[2]));
  seq_det_param #(.N(4), .PATTERN(4'b1111), .OVERLAP(1'b0), .CNT_W(8)) d3 (
    .clk(clk), .rst(rst), .i(i), .en(en), .clr(clr), .q(q_w[3]), .match_cnt(cnt_w[3]));
  seq_det_param #(.N(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CNT_W(2)) d4 (
    .clk(clk), .rst(rst), .i(i), .en(en), .clr(clr), .q(q_w[4]), .match_cnt(cnt4));

  assign cnt_w[4] = {6'd0, cnt4};

  logic [15:0] hist    [NI];
  int          since   [NI];
  logic        exp_q   [NI];
  int          exp_cnt [NI];
  int          tests = 0;
  int          fails = 0;

  // A match is "last N accepted bits equal the pattern" with enough fresh bits.
  task automatic model(input logic ii, input logic ee, input logic rr, input logic cc);
    logic m;
    for (int k = 0; k < NI; k++) begin
      if (rr) begin
        hist[k] = '0; since[k] = 0; exp_q[k] = 1'b0; exp_cnt[k] = 0;
      end else begin
        m = 1'b0;
        if (ee) begin
          hist[k]  = {hist[k][14:0], ii};
          since[k] = since[k] + 1;
          if (since[k] >= cfg_n[k] &&
              (hist[k] & ((16'd1 << cfg_n[k]) - 16'd1)) == cfg_pat[k]) m = 1'b1;
          if (m && !cfg_ovl[k]) since[k] = 0;
        end
        exp_q[k] = m;
`ifdef SEQ_DET_CNT_EN
        if (cc) exp_cnt[k] = 0;
        else if (m && exp_cnt[k] < cfg_max[k]) exp_cnt[k] = exp_cnt[k] + 1;
`else
        exp_cnt[k] = 0;
`endif
      end
    end
  endtask

  task automatic check(input string tag);
    for (int k = 0; k < NI; k++) begin
      tests++;
      assert (q_w[k] === exp_q[k]) else begin
        fails++;
        $error("FAIL %s q[%0d] observed %b expected %b", tag, k, q_w[k], exp_q[k]);
      end
      tests++;
      assert (cnt_w[k] === 8'(exp_cnt[k])) else begin
        fails++;
        $error("FAIL %s cnt[%0d] observed %0d expected %0d", tag, k, cnt_w[k], exp_cnt[k]);
      end
    end
  endtask

  task automatic step(input logic ii, input logic ee, input logic rr, input logic cc,
                      input string tag);
    i = ii; en = ee; rst = rr; clr = cc;
    @(posedge clk);
    model(ii, ee, rr, cc);
    #1;
    check(tag);
  endtask

  initial begin
    logic [10:0] alt;
    alt = 11'b10101010101;
    for (int k = 0; k < NI; k++) begin
      hist[k] = '0; since[k] = 0; exp_q[k] = 1'b0; exp_cnt[k] = 0;
    end
    i = 1'b0; en = 1'b0; rst = 1'b1; clr = 1'b0;

    step(0, 1, 1, 1, "reset");
    step(1, 1, 1, 0, "reset_hold");

    // 1,0,1,0,1 then 0,1
    step(1, 1, 0, 0, "seq_a"); step(0, 1, 0, 0, "seq_a"); step(1, 1, 0, 0, "seq_a");
    step(0, 1, 0, 0, "seq_a"); step(1, 1, 0, 0, "seq_a");
    step(0, 1, 0, 0, "seq_b"); step(1, 1, 0, 0, "seq_b");

    // en gap with toggling i
    step(1, 1, 1, 0, "gap_rst");
    step(1, 1, 0, 0, "gap"); step(0, 1, 0, 0, "gap");
    step(1, 0, 0, 0, "gap_off"); step(0, 0, 0, 0, "gap_off"); step(1, 0, 0, 0, "gap_off");
    step(1, 1, 0, 0, "gap_on"); step(0, 0, 0, 0, "gap_after");

    // six ones
    step(0, 1, 1, 0, "ones_rst");
    for (int n = 0; n < 6; n++) step(1, 1, 0, 0, "ones");

    // reset mid-match discards history
    step(0, 1, 1, 0, "mid_rst");
    step(1, 1, 0, 0, "mid"); step(0, 1, 0, 0, "mid");
    step(1, 1, 1, 0, "mid_rst2");
    step(1, 1, 0, 0, "mid_after");

    // five overlapping matches saturate the 2-bit counter, then clr on a match
    step(0, 1, 1, 0, "sat_rst");
    for (int n = 10; n >= 0; n--) step(alt[n], 1, 0, 0, "sat");
    step(0, 1, 0, 0, "clr_hit"); step(1, 1, 0, 1, "clr_hit");
    step(0, 1, 0, 0, "clr_after"); step(1, 1, 0, 0, "clr_after");

    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom), ($urandom_range(3) != 0), ($urandom_range(60) == 0),
           ($urandom_range(25) == 0), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
